merge_fill_arbiter: RTL and testbench
=====================================

Name: merge_fill_arbiter

Overview:
- Schedules refills of the two input FIFOs (A and B) of a two-way merge unit from one shared memory read port.
- Each grant issues one BURST-word read request for the chosen side.
- Tracks in-flight words per side so a FIFO is never over-committed.
- Favours the emptier FIFO so the merge control stalls on an empty input as rarely as possible. Sits between the merger's input FIFOs and the memory read interface.

Parameters:
DEPTH, 16, entries per input FIFO
CNT_W, 5, width of occupancy and credit arithmetic (holds 0..DEPTH)
BURST, 4, words returned per request
MAX_OUT, 4, max outstanding requests, both sides combined

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_a_count  in  CNT_W  current occupancy of FIFO A
i_b_count  in  CNT_W  current occupancy of FIFO B
i_a_src_done  in  1  source A has no more data to fetch (level)
i_b_src_done  in  1  source B has no more data to fetch (level)
o_req_valid  out  1  read request valid
o_req_sel  out  1  request side: 0=A, 1=B
i_req_ready  in  1  memory accepts request this cycle
i_rsp_valid  in  1  one response word returned
i_rsp_sel  in  1  side of returned word (in order per side)
o_done  out  1  both sources done, nothing in flight (sticky)
o_err  out  1  sticky: response beat for a side with zero in-flight

Behaviour:
- Reset (i_rst high at clock edge): state IDLE; o_req_valid=0, o_req_sel=0, o_done=0, o_err=0; infl_a=infl_b=0 (in-flight words); outstanding=0; beat counters=0; last_grant=B, so the first tie goes to A. Reset mid-burst discards all tracking. In-flight responses after reset count as errors.
- Per-side fill: fill_x = i_x_count + infl_x, computed CNT_W+1 wide.
- Eligibility: elig_x = ~i_x_src_done & (DEPTH - fill_x >= BURST) & (outstanding < MAX_OUT).
- Arbitration, evaluated in IDLE only:
  - Exactly one side eligible -> that side.
  - Both eligible -> side with smaller fill_x.
  - Equal fill -> side opposite last_grant.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if any side eligible, latch o_req_sel, set o_req_valid=1, go to REQ at next edge. Latency is exactly 1 cycle from sampled eligibility to o_req_valid.
  - IDLE -> DONE when i_a_src_done & i_b_src_done & outstanding==0 & no request pending.
  - REQ: o_req_valid and o_req_sel held stable until i_req_ready. On the accepting edge: infl_sel += BURST, outstanding += 1, last_grant = sel, o_req_valid=0, return to IDLE. Maximum issue rate is one request per 2 cycles.
  - REQ ignores changes to src_done; an issued request always completes.
  - DONE: o_done=1, o_req_valid=0. Held until reset.
- Responses:
  - Each i_rsp_valid beat decrements infl_sel by 1 and increments beat_cnt_sel.
  - When beat_cnt_sel reaches BURST, it wraps to 0 and outstanding decrements by 1.
  - Beat for a side with infl==0: counters unchanged, o_err=1 (sticky).
- Simultaneous events:
  - Accept and response beat on the same side in one cycle: infl_x += BURST-1.
  - Accept plus burst completion in one cycle: outstanding unchanged.
  - All counter updates are computed from pre-edge values in a single always block, with no double counting.
- Occupancy inputs are trusted. fill_x > DEPTH makes the side ineligible; no underflow in the DEPTH - fill_x compare (use the wide compare fill_x + BURST <= DEPTH).
- No combinational path from any input to o_req_valid or o_req_sel; both are registered.

Test Plan:
- Reset then a_count=0, b_count=0, neither done -> cycle+1: req_valid=1, sel=0 (tie, A first). Accept -> next grant sel=1, infl_a=4.
- a_count=10, b_count=2, ready always 1 -> grants B each request until fill_b=10 (two grants: fill 6, then 10), then tie -> sel alternates; no grant once both fills exceed 12.
- Hold i_req_ready=0 for 5 cycles with sel=1 while a_count drops to 0 -> o_req_sel stays 1, o_req_valid stays 1; A granted only after accept.
- ready=1, no responses -> exactly 4 requests accepted, then req_valid stays 0. One full 4-beat response -> exactly one more request issued.
- Same-cycle accept on A and response beat on A with infl_a=4 -> infl_a=7. Outstanding correct after burst completion.
- Both src_done asserted with 2 outstanding -> o_done stays 0 until the 8th beat, then 1 next cycle. An extra beat -> o_err=1.

Source files
------------

// File: rtl/merge_fill_arbiter.sv
// merge_fill_arbiter: schedules BURST-word refills of the two input FIFOs of a
// two-way merger from a single shared memory read port. In-flight words are
// tracked per side so neither FIFO is over-committed, and the emptier FIFO is
// preferred so the merger rarely stalls on an empty input.
module merge_fill_arbiter #(
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 5,
    parameter int BURST   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_a_count,
    input  logic [CNT_W-1:0] i_b_count,
    input  logic             i_a_src_done,
    input  logic             i_b_src_done,
    output logic             o_req_valid,
    output logic             o_req_sel,
    input  logic             i_req_ready,
    input  logic             i_rsp_valid,
    input  logic             i_rsp_sel,
    output logic             o_done,
    output logic             o_err
);

    // Fill arithmetic is two bits wider than CNT_W so count + infl + BURST never wraps.
    localparam int FW = CNT_W + 2;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] infl_a_r;
    logic [CNT_W-1:0] infl_b_r;
    logic [OW-1:0]    outst_r;
    logic [BW-1:0]    beat_a_r;
    logic [BW-1:0]    beat_b_r;
    logic             last_grant_r;

    logic [FW-1:0]    fill_a_s;
    logic [FW-1:0]    fill_b_s;
    logic             elig_a_s;
    logic             elig_b_s;
    logic             pick_b_s;
    logic             done_cond_s;

    logic             accept_s;
    logic             beat_a_s;
    logic             beat_b_s;
    logic             bad_beat_s;
    logic             cmp_a_s;
    logic             cmp_b_s;
    logic [CNT_W-1:0] infl_a_nxt_s;
    logic [CNT_W-1:0] infl_b_nxt_s;
    logic [BW-1:0]    beat_a_nxt_s;
    logic [BW-1:0]    beat_b_nxt_s;
    logic [OW-1:0]    outst_nxt_s;

    // Per-side fill level and eligibility for a new burst.
    always_comb begin
        fill_a_s = FW'(i_a_count) + FW'(infl_a_r);
        fill_b_s = FW'(i_b_count) + FW'(infl_b_r);
        elig_a_s = ~i_a_src_done && ((fill_a_s + FW'(BURST)) <= FW'(DEPTH))
                   && (outst_r < OW'(MAX_OUT));
        elig_b_s = ~i_b_src_done && ((fill_b_s + FW'(BURST)) <= FW'(DEPTH))
                   && (outst_r < OW'(MAX_OUT));
        done_cond_s = i_a_src_done && i_b_src_done && (outst_r == {OW{1'b0}});
    end

    // Side selection: lone eligible side, else emptier side, else alternate on a tie.
    always_comb begin
        pick_b_s = 1'b0;
        if (elig_a_s && elig_b_s) begin
            if (fill_b_s < fill_a_s) begin
                pick_b_s = 1'b1;
            end else if (fill_a_s < fill_b_s) begin
                pick_b_s = 1'b0;
            end else begin
                pick_b_s = ~last_grant_r;
            end
        end else if (elig_b_s) begin
            pick_b_s = 1'b1;
        end else begin
            pick_b_s = 1'b0;
        end
    end

    // Request acceptance and response beat classification.
    always_comb begin
        accept_s   = (state_r == ST_REQ) && i_req_ready;
        beat_a_s   = i_rsp_valid && ~i_rsp_sel && (infl_a_r != {CNT_W{1'b0}});
        beat_b_s   = i_rsp_valid &&  i_rsp_sel && (infl_b_r != {CNT_W{1'b0}});
        bad_beat_s = i_rsp_valid && ~beat_a_s && ~beat_b_s;
    end

    // Beat counters per side; a wrap marks a completed burst.
    always_comb begin
        beat_a_nxt_s = beat_a_r;
        cmp_a_s      = 1'b0;
        if (beat_a_s) begin
            if (beat_a_r == BW'(BURST - 1)) begin
                beat_a_nxt_s = {BW{1'b0}};
                cmp_a_s      = 1'b1;
            end else begin
                beat_a_nxt_s = beat_a_r + BW'(1);
            end
        end else begin
            beat_a_nxt_s = beat_a_r;
        end
        beat_b_nxt_s = beat_b_r;
        cmp_b_s      = 1'b0;
        if (beat_b_s) begin
            if (beat_b_r == BW'(BURST - 1)) begin
                beat_b_nxt_s = {BW{1'b0}};
                cmp_b_s      = 1'b1;
            end else begin
                beat_b_nxt_s = beat_b_r + BW'(1);
            end
        end else begin
            beat_b_nxt_s = beat_b_r;
        end
    end

    // Next in-flight and outstanding counts, combining grant and response deltas.
    always_comb begin
        infl_a_nxt_s = infl_a_r
                       + ((accept_s && ~o_req_sel) ? CNT_W'(BURST) : {CNT_W{1'b0}})
                       - (beat_a_s ? CNT_W'(1) : {CNT_W{1'b0}});
        infl_b_nxt_s = infl_b_r
                       + ((accept_s && o_req_sel) ? CNT_W'(BURST) : {CNT_W{1'b0}})
                       - (beat_b_s ? CNT_W'(1) : {CNT_W{1'b0}});
        outst_nxt_s  = outst_r
                       + (accept_s ? OW'(1) : {OW{1'b0}})
                       - (cmp_a_s ? OW'(1) : {OW{1'b0}})
                       - (cmp_b_s ? OW'(1) : {OW{1'b0}});
    end

    // Control FSM plus all tracking state, updated together from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            o_req_valid  <= 1'b0;
            o_req_sel    <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            infl_a_r     <= {CNT_W{1'b0}};
            infl_b_r     <= {CNT_W{1'b0}};
            outst_r      <= {OW{1'b0}};
            beat_a_r     <= {BW{1'b0}};
            beat_b_r     <= {BW{1'b0}};
            last_grant_r <= 1'b1;
        end else begin
            infl_a_r <= infl_a_nxt_s;
            infl_b_r <= infl_b_nxt_s;
            outst_r  <= outst_nxt_s;
            beat_a_r <= beat_a_nxt_s;
            beat_b_r <= beat_b_nxt_s;
            if (bad_beat_s) begin
                o_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (done_cond_s) begin
                        state_r     <= ST_DONE;
                        o_done      <= 1'b1;
                        o_req_valid <= 1'b0;
                    end else if (elig_a_s || elig_b_s) begin
                        state_r     <= ST_REQ;
                        o_req_valid <= 1'b1;
                        o_req_sel   <= pick_b_s;
                    end
                end
                ST_REQ: begin
                    // Held stable until accepted; src_done changes do not cancel it.
                    if (i_req_ready) begin
                        state_r      <= ST_IDLE;
                        o_req_valid  <= 1'b0;
                        last_grant_r <= o_req_sel;
                    end
                end
                ST_DONE: begin
                    o_done      <= 1'b1;
                    o_req_valid <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    o_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_fill_arbiter.sv
// Self-checking bench for merge_fill_arbiter: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_merge_fill_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [4:0] i_a_count;
    logic [4:0] i_b_count;
    logic       i_a_src_done;
    logic       i_b_src_done;
    logic       o_req_valid;
    logic       o_req_sel;
    logic       i_req_ready;
    logic       i_rsp_valid;
    logic       i_rsp_sel;
    logic       o_done;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    // Reference model: bursts issued and words returned per side.
    int iss_a, iss_b, ret_a, ret_b;
    bit m_last, m_pend, m_sel, m_done, m_err;

    merge_fill_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_a_count    (i_a_count),
        .i_b_count    (i_b_count),
        .i_a_src_done (i_a_src_done),
        .i_b_src_done (i_b_src_done),
        .o_req_valid  (o_req_valid),
        .o_req_sel    (o_req_sel),
        .i_req_ready  (i_req_ready),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_sel    (i_rsp_sel),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int infl(input bit side);
        return side ? (iss_b * 4 - ret_b) : (iss_a * 4 - ret_a);
    endfunction

    function automatic int outst();
        return (iss_a - ret_a / 4) + (iss_b - ret_b / 4);
    endfunction

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst, input int ac, input int bc, input bit ad,
                        input bit bd, input bit rdy, input bit rv, input bit rs);
        int ia, ib, o, fa, fb;
        bit ea, eb, acc;
        i_rst = rst; i_a_count = 5'(ac); i_b_count = 5'(bc);
        i_a_src_done = ad; i_b_src_done = bd; i_req_ready = rdy;
        i_rsp_valid = rv; i_rsp_sel = rs;
        if (rst) begin
            iss_a = 0; iss_b = 0; ret_a = 0; ret_b = 0;
            m_last = 1'b1; m_pend = 1'b0; m_sel = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            ia = infl(1'b0); ib = infl(1'b1); o = outst();
            fa = ac + ia; fb = bc + ib;
            ea = !ad && (fa + 4 <= 16) && (o < 4);
            eb = !bd && (fb + 4 <= 16) && (o < 4);
            acc = m_pend && rdy;
            if (rv) begin
                if ((rs ? ib : ia) > 0) begin
                    if (rs) ret_b++; else ret_a++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (acc) begin
                if (m_sel) iss_b++; else iss_a++;
                m_last = m_sel;
                m_pend = 1'b0;
            end else if (!m_pend && !m_done) begin
                if (ad && bd && o == 0) begin
                    m_done = 1'b1;
                end else if (ea || eb) begin
                    m_pend = 1'b1;
                    if (ea && eb) m_sel = (fa == fb) ? !m_last : (fb < fa);
                    else m_sel = eb;
                end
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check("req_valid", o_req_valid, m_pend);
        if (m_pend) check("req_sel", o_req_sel, m_sel);
        check("done", o_done, m_done);
        check("err", o_err, m_err);
    endtask

    // Random cycle: legal beats only, on a side that has words in flight.
    task automatic rnd_step(input bit ad, input bit bd, input int p_rsp);
        bit rs, rv;
        rs = 1'($urandom_range(0, 1));
        if (infl(rs) == 0) rs = !rs;
        rv = (infl(rs) > 0) && ($urandom_range(0, 99) < p_rsp);
        step(1'b0, $urandom_range(0, 20), $urandom_range(0, 20), ad, bd,
             $urandom_range(0, 99) < 70, rv, rs);
    endtask

    initial begin
        @(negedge i_clk);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", o_req_valid, 0);
        check("rst_sel", o_req_sel, 0);

        // First tie goes to A, then B after A's burst is in flight.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("first_sel_a", o_req_sel, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("second_sel_b", o_req_sel, 1);

        // Emptier-side preference, alternation on ties, stop when full.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 10, 2, 0, 0, 1, 0, 0);
        check("full_no_req", o_req_valid, 0);

        // Request held stable while not ready although A becomes emptier.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 16, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("hold_sel", o_req_sel, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("after_hold_a", o_req_sel, 0);

        // Same-cycle accept and beat on A, then outstanding limit and refill.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 16, 0, 0, 1, 0, 0);
        step(0, 0, 16, 0, 0, 1, 0, 0);
        step(0, 0, 16, 0, 0, 0, 0, 0);
        step(0, 0, 16, 0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0, 0);

        // Random traffic with occasional mid-run resets.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1, 0, 0, 0, 0, 0, 0, 0);
                step(0, 20, 20, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
            end else begin
                rnd_step(1'b0, 1'b0, 50);
            end
        end
        for (int i = 0; i < 400 && !m_done; i++) rnd_step(1'b1, 1'b1, 80);
        check("drain_done", o_done, 1);

        // Done only after the eighth beat of two outstanding bursts; extra beat errors.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 1, 0, 1, 1'(i % 2));
            check("done_wait", o_done, 0);
        end
        step(0, 0, 0, 1, 1, 0, 0, 0);
        check("done_set", o_done, 1);
        step(0, 0, 0, 1, 1, 0, 1, 0);
        check("extra_beat_err", o_err, 1);
        step(0, 0, 0, 1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
